// File: rtl/fifo_pkg.sv
// Shared constants, count-width helper and status bundle for the parametrised FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int FIFO_DEPTH      = 8;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
    logic wr_ack;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param; master = FIFO user, slave = FIFO.
interface sync_fifo_param_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and per-cycle strobes.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_param_if.slave   bus
);

  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack, r_overflow, r_underflow;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_full, w_empty, w_wr, w_rd;
  fifo_status_t          w_status;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = bus.wr_en && !w_full;
  assign w_rd    = bus.rd_en && !w_empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PTR_W)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
      r_wr_ack    <= w_wr;
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = w_rdata;
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_dout <= '0;
    else if (w_rd) r_dout <= w_rdata;
  end

  assign bus.data_out = r_dout;
`endif

  always_comb begin
    w_status             = '0;
    w_status.full        = w_full;
    w_status.empty       = w_empty;
    w_status.almostfull  = (r_count >= CNT_W'(DEPTH - AF_MARGIN));
    w_status.almostempty = (r_count <= CNT_W'(AE_MARGIN)) && !w_empty;
    w_status.overflow    = r_overflow;
    w_status.underflow   = r_underflow;
    w_status.wr_ack      = r_wr_ack;
  end

  assign bus.full        = w_status.full;
  assign bus.empty       = w_status.empty;
  assign bus.almostfull  = w_status.almostfull;
  assign bus.almostempty = w_status.almostempty;
  assign bus.overflow    = w_status.overflow;
  assign bus.underflow   = w_status.underflow;
  assign bus.wr_ack      = w_status.wr_ack;
  assign bus.count       = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AFM),
    .AE_MARGIN  (AEM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  fifo_status_t dut_st;
  assign dut_st = {bus.full, bus.empty, bus.almostfull, bus.almostempty,
                   bus.overflow, bus.underflow, bus.wr_ack};

  // Reference model: contents as a queue plus last-cycle strobes.
  logic [DW-1:0] q[$];
  logic          m_wack, m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  function automatic fifo_status_t exp_st();
    fifo_status_t s;
    int n = q.size();
    s.full        = (n == DEPTH);
    s.empty       = (n == 0);
    s.almostfull  = (n >= DEPTH - AFM);
    s.almostempty = (n <= AEM) && (n != 0);
    s.overflow    = m_ovf;
    s.underflow   = m_unf;
    s.wr_ack      = m_wack;
    return s;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(q.size());
  endfunction

`ifdef SYNC_FIFO_FWFT_EN
  function automatic bit dout_care();
    return q.size() != 0;
  endfunction
  function automatic logic [DW-1:0] exp_dout();
    return q[0];
  endfunction
`else
  function automatic bit dout_care();
    return 1'b1;
  endfunction
  function automatic logic [DW-1:0] exp_dout();
    return m_dout;
  endfunction
`endif

  // Drive one clock of stimulus; called and returns at posedge+1.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d);
    bit f, e, wa, ra;
    bus.wr_en = we; bus.rd_en = re; bus.data_in = d;
    @(posedge clk);
    f  = (q.size() == DEPTH);
    e  = (q.size() == 0);
    wa = we && !f;
    ra = re && !e;
    m_wack = wa; m_ovf = we && f; m_unf = re && e;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_wack = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
  endtask

  task automatic test_reset();
    fifo_status_t rs;
    rs = '0; rs.empty = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_chk++; if (dut_st !== rs) begin n_err++; $display("FAIL reset_status got=%b exp=%b", dut_st, rs); end
    n_chk++; if (bus.count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
`ifndef SYNC_FIFO_FWFT_EN
    n_chk++; if (bus.data_out !== '0) begin n_err++; $display("FAIL reset_dout got=%h exp=0", bus.data_out); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL fill_status i=%0d got=%b exp=%b", i, dut_st, exp_st()); end
      n_chk++; if (bus.count !== exp_cnt()) begin n_err++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
    end
    cycle(1'b1, 1'b0, 16'hDEAD);
    n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL ovf_status got=%b exp=%b", dut_st, exp_st()); end
    n_chk++; if (bus.count !== CW'(DEPTH) || bus.overflow !== 1'b1 || bus.wr_ack !== 1'b0) begin
      n_err++; $display("FAIL ovf_flags count=%0d ovf=%b ack=%b exp 8/1/0", bus.count, bus.overflow, bus.wr_ack);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (dout_care()) begin
        n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL drain_head i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
`endif
      cycle(1'b0, 1'b1, '0);
      n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL drain_status i=%0d got=%b exp=%b", i, dut_st, exp_st()); end
      n_chk++; if (bus.count !== exp_cnt()) begin n_err++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
      if (dout_care()) begin
        n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
    end
    n_chk++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL drain_unf got=%b exp=1", bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
    n_chk++; if (bus.data_out !== 16'h0008) begin n_err++; $display("FAIL drain_hold got=%h exp=0008", bus.data_out); end
`endif
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, DW'(16'h00A0 + i));
      n_chk++; if (bus.count !== CW'(4)) begin n_err++; $display("FAIL simul_count i=%0d got=%0d exp=4", i, bus.count); end
      n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL simul_status i=%0d got=%b exp=%b", i, dut_st, exp_st()); end
      if (dout_care()) begin
        n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL simul_dout i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0);
      if (dout_care()) begin
        n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
    end
  endtask

  task automatic test_boundary();
    while (q.size() > 0) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 16'h5A5A);
    n_chk++; if (bus.count !== CW'(1) || bus.underflow !== 1'b1 || bus.wr_ack !== 1'b1) begin
      n_err++; $display("FAIL bnd_empty count=%0d unf=%b ack=%b exp 1/1/1", bus.count, bus.underflow, bus.wr_ack);
    end
    n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL bnd_empty_status got=%b exp=%b", dut_st, exp_st()); end
    while (q.size() < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, 16'hBEEF);
    n_chk++; if (bus.count !== CW'(DEPTH - 1) || bus.overflow !== 1'b1 || bus.wr_ack !== 1'b0) begin
      n_err++; $display("FAIL bnd_full count=%0d ovf=%b ack=%b exp 7/1/0", bus.count, bus.overflow, bus.wr_ack);
    end
    n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL bnd_full_status got=%b exp=%b", dut_st, exp_st()); end
    if (dout_care()) begin
      n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL bnd_full_dout got=%h exp=%h", bus.data_out, exp_dout()); end
    end
  endtask

  task automatic test_random_reset();
    fifo_status_t rs;
    rs = '0; rs.empty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 1'($urandom), DW'($urandom));
      n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL rnd_status i=%0d got=%b exp=%b", i, dut_st, exp_st()); end
      n_chk++; if (bus.count !== exp_cnt()) begin n_err++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, bus.count, exp_cnt()); end
      if (dout_care()) begin
        n_chk++; if (bus.data_out !== exp_dout()) begin n_err++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, bus.data_out, exp_dout()); end
      end
    end
    while (q.size() < 5) cycle(1'b1, 1'b0, DW'($urandom));
    while (q.size() > 5) cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, DW'($urandom));
    n_chk++; if (bus.count !== CW'(6)) begin n_err++; $display("FAIL pre_reset_count got=%0d exp=6", bus.count); end
    cycle(1'b0, 1'b1, '0);
    // Assert reset between clock edges; outputs must clear before the next edge.
    #2; rst_n = 1'b0; #1;
    n_chk++; if (dut_st !== rs) begin n_err++; $display("FAIL async_rst_status got=%b exp=%b", dut_st, rs); end
    n_chk++; if (bus.count !== '0) begin n_err++; $display("FAIL async_rst_count got=%0d exp=0", bus.count); end
`ifndef SYNC_FIFO_FWFT_EN
    n_chk++; if (bus.data_out !== '0) begin n_err++; $display("FAIL async_rst_dout got=%h exp=0", bus.data_out); end
`endif
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 16'h1234);
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (bus.data_out !== 16'h1234) begin n_err++; $display("FAIL post_rst_dout got=%h exp=1234", bus.data_out); end
`endif
    cycle(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
    n_chk++; if (bus.data_out !== 16'h1234) begin n_err++; $display("FAIL post_rst_dout got=%h exp=1234", bus.data_out); end
`endif
    n_chk++; if (dut_st !== exp_st()) begin n_err++; $display("FAIL post_rst_status got=%b exp=%b", dut_st, exp_st()); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain();
    test_simul();
    test_boundary();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
